uc_secuenciador: RTL and testbench
==================================

// Module: uc_secuenciador
// PURPOSE
//  Multi-cycle control unit for the microc datapath.
//  - Decodes Opcode into the datapath selects: s_skip, s_inc, s_inm, we, ALUOp.
//  - Sequences every instruction as FETCH then EXEC. Program memory has a 1-cycle synchronous read.
//  - Holds the Z/C flag register used by conditional branches.
//  - Drives pc_en. The datapath PC register loads new_pc only when pc_en=1.
// PARAMETERS
//  INIT_CYCLES  1  idle cycles after reset release before the first FETCH (memprog warm-up); legal range 1..15
// PORTS
//  clk      in   1  system clock, rising edge
//  reset    in   1  asynchronous, active-low; 0 forces the reset state immediately
//  Opcode   in   6  instruction[15:10] from memprog; decode uses Opcode[5:2] only
//  zero     in   1  ALU zero output, combinational, valid during EXEC
//  carry    in   1  ALU carry output, combinational, valid during EXEC
//  s_skip   out  1  PC increment select: 0 = +1, 1 = +2
//  s_inc    out  1  1 = PC+inc, 0 = jump to instruction[9:0]
//  s_inm    out  1  1 = WD3 takes immediate instruction[11:4]
//  we       out  1  regfile write enable
//  ALUOp    out  3  ALU operation
//  pc_en    out  1  PC load enable
//  halted   out  1  1 while in HALT
// BEHAVIOUR
//  State machine and flags:
//  - States: INIT, FETCH, EXEC, HALT. Flags: registered zf and cf.
//  - Reset (reset=0, async): state=INIT, init counter=INIT_CYCLES, zf=0, cf=0.
//  Idle outputs (every state except EXEC):
//  - we=0, pc_en=0, s_inc=1, s_skip=0, s_inm=0, ALUOp=000.
//  - halted=1 only in HALT.
//  Transitions:
//  - INIT: counter decrements each cycle; goes to FETCH on the cycle it reaches 0. First FETCH is at clock edge INIT_CYCLES after reset release.
//  - FETCH -> EXEC always. This is the memprog read cycle; Opcode is valid in EXEC.
//  - EXEC -> FETCH, or -> HALT on opcode 1111.
//  - HALT: absorbing; only reset leaves it.
//  EXEC decode on Opcode[5:2]; outputs are combinational from state + Opcode + flags.
//  - 0aaa  ALU op: ALUOp=aaa, we=1, pc_en=1, s_inc=1. At the EXEC edge zf<=zero and cf<=carry.
//  - 1000  LI: s_inm=1, we=1, pc_en=1, s_inc=1.
//  - 1001  J: s_inc=0, pc_en=1.
//  - 1010  JZ: s_inc = ~zf, pc_en=1.
//  - 1011  JNZ: s_inc = zf, pc_en=1.
//  - 1100  JC: s_inc = ~cf, pc_en=1.
//  - 1101  SKZ: s_skip = zf, s_inc=1, pc_en=1 (skips the next instruction when Z is set).
//  - 1110  NOP: pc_en=1, s_inc=1.
//  - 1111  HALT: pc_en=0, we=0; next state HALT.
//  Flag rules:
//  - Only ALU ops (0aaa) update zf and cf. LI, jumps, SKZ, NOP and HALT leave the flags unchanged.
//  - Conditional branches use the registered flags, never the live zero/carry.
//  - An ALU op followed by JZ tests that ALU op's result.
//  Timing:
//  - CPI = 2 for every instruction except HALT.
//  - PC wraps 0x3FF -> 0x000 in the datapath adder. The controller does not detect or block this.
//  Reset mid-operation:
//  - Asserting reset in EXEC cancels that instruction: we and pc_en drop asynchronously, so there is no write or PC update.
//  - The flags are cleared.
// TESTING
//  - Reset release, INIT_CYCLES=1 -> INIT one cycle, then FETCH/EXEC alternate; we=pc_en=0 in INIT and FETCH.
//  - EXEC Opcode=6'b010100 (ALU op 101), zero=1, carry=0 -> ALUOp=101, we=1, pc_en=1; next cycle zf=1, cf=0.
//  - zf=1, EXEC JZ (1010xx) -> s_inc=0.  zf=0, EXEC JZ -> s_inc=1.  zf=0, EXEC JNZ -> s_inc=0.
//  - zf=1, EXEC SKZ -> s_skip=1, s_inc=1; with zf=0 -> s_skip=0.
//  - Flags hold: ALU op with zero=1, then LI executed while the zero input=0 -> zf stays 1 and the following JZ jumps.
//  - EXEC HALT (1111xx) -> halted=1 next cycle and pc_en=0 forever; reset low in EXEC of an ALU op -> we=0 at once, zf=cf=0.

Source files
------------

// File: rtl/uc_secuenciador_if.sv
// Bus between the microc control unit and its datapath: opcode and ALU
// status flow into the controller, datapath selects flow back out.
interface uc_secuenciador_if;
  logic [5:0] Opcode;
  logic       zero;
  logic       carry;
  logic       s_skip;
  logic       s_inc;
  logic       s_inm;
  logic       we;
  logic [2:0] ALUOp;
  logic       pc_en;
  logic       halted;

  modport master (
    input  Opcode, zero, carry,
    output s_skip, s_inc, s_inm, we, ALUOp, pc_en, halted
  );

  modport slave (
    output Opcode, zero, carry,
    input  s_skip, s_inc, s_inm, we, ALUOp, pc_en, halted
  );
endinterface

// File: rtl/uc_secuenciador.sv
// Multi-cycle control unit for the microc datapath. Every instruction takes
// a FETCH cycle (program memory read) and an EXEC cycle (decode + commit).
// The Z/C flags are registered here so conditional branches see the result
// of the most recent ALU operation, not the live ALU outputs.
module uc_secuenciador #(
  parameter int unsigned INIT_CYCLES = 1
) (
  input logic           clk,
  input logic           reset,
  uc_secuenciador_if.master bus
);

  typedef enum logic [1:0] {INIT, FETCH, EXEC, HALT} state_t;

  localparam logic [3:0] INIT_LOAD = 4'(INIT_CYCLES);

  state_t     state, state_nxt;
  logic [3:0] init_cnt;
  logic       zf, cf;
  logic [3:0] op;

  // The two opcode LSBs belong to the operand field and do not affect decode.
  logic unused_op_lsbs;
  assign unused_op_lsbs = ^bus.Opcode[1:0];

  assign op = bus.Opcode[5:2];

  // Sequencer state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= INIT;
    else        state <= state_nxt;
  end

  // Warm-up counter: lets program memory settle before the first fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                init_cnt <= INIT_LOAD;
    else if (state == INIT && init_cnt != 4'd0) init_cnt <= init_cnt - 4'd1;
  end

  // Flag register: only ALU operations (opcode MSB clear) capture Z/C.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      zf <= 1'b0;
      cf <= 1'b0;
    end else if (state == EXEC && !op[3]) begin
      zf <= bus.zero;
      cf <= bus.carry;
    end
  end

  // Next-state: leave INIT on the edge the counter reaches zero; HALT absorbs.
  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (init_cnt <= 4'd1) state_nxt = FETCH;
      FETCH:   state_nxt = EXEC;
      EXEC:    state_nxt = (op == 4'b1111) ? HALT : FETCH;
      HALT:    state_nxt = HALT;
      default: state_nxt = INIT;
    endcase
  end

  // Datapath selects: idle values everywhere except EXEC, where the opcode decodes.
  always_comb begin
    bus.s_skip = 1'b0;
    bus.s_inc  = 1'b1;
    bus.s_inm  = 1'b0;
    bus.we     = 1'b0;
    bus.ALUOp  = 3'b000;
    bus.pc_en  = 1'b0;
    bus.halted = (state == HALT);
    if (state == EXEC) begin
      if (!op[3]) begin
        bus.ALUOp = op[2:0];
        bus.we    = 1'b1;
        bus.pc_en = 1'b1;
      end else begin
        case (op[2:0])
          3'b000: begin bus.s_inm = 1'b1; bus.we = 1'b1; bus.pc_en = 1'b1; end
          3'b001: begin bus.s_inc = 1'b0;   bus.pc_en = 1'b1; end
          3'b010: begin bus.s_inc = ~zf;    bus.pc_en = 1'b1; end
          3'b011: begin bus.s_inc = zf;     bus.pc_en = 1'b1; end
          3'b100: begin bus.s_inc = ~cf;    bus.pc_en = 1'b1; end
          3'b101: begin bus.s_skip = zf;    bus.pc_en = 1'b1; end
          3'b110: bus.pc_en = 1'b1;
          default: bus.pc_en = 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uc_secuenciador.sv
// Bench for uc_secuenciador: constant-table decode vectors, hand-written
// multi-cycle sequences and randomized opcodes checked against a cycle-count
// model of the FETCH/EXEC sequence with its own flag register.
module tb_uc_secuenciador;

  localparam int INIT = 1;
  localparam int ST_INIT = 0, ST_FETCH = 1, ST_EXEC = 2, ST_HALT = 3;
  // Output vector order: {s_skip, s_inc, s_inm, we, ALUOp[2:0], pc_en, halted}
  localparam logic [8:0] IDLE = 9'b0_1_0_0_000_0_0;

  logic clk = 1'b0;
  logic reset = 1'b0;
  uc_secuenciador_if bus();

  uc_secuenciador #(.INIT_CYCLES(INIT)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: edges since reset release, halt seen, and the architectural flags.
  int   m_k    = 0;
  logic m_halt = 1'b0;
  logic m_zf   = 1'b0;
  logic m_cf   = 1'b0;
  logic [8:0] last_out;

  function automatic logic [8:0] dut_out();
    return {bus.s_skip, bus.s_inc, bus.s_inm, bus.we, bus.ALUOp, bus.pc_en, bus.halted};
  endfunction

  function automatic int m_state();
    if (m_halt)   return ST_HALT;
    if (m_k < INIT) return ST_INIT;
    return (((m_k - INIT) % 2) == 0) ? ST_FETCH : ST_EXEC;
  endfunction

  // Expected selects from the instruction's meaning: ALU writes, LI writes an
  // immediate, branches redirect the PC when their condition holds.
  function automatic logic [8:0] m_expect(int st, logic [5:0] opc, logic zf, logic cf);
    logic skip, inc, inm, wr, pce, taken;
    logic [2:0] alu;
    logic [3:0] k;
    if (st != ST_EXEC) return {IDLE[8:1], st == ST_HALT};
    k = opc[5:2];
    skip = 1'b0; inm = 1'b0; wr = 1'b0; alu = 3'b000; taken = 1'b0;
    pce = (k != 4'hF);
    if (k < 4'd8) begin alu = k[2:0]; wr = 1'b1; end
    else if (k == 4'd8) begin inm = 1'b1; wr = 1'b1; end
    else if (k == 4'd9)  taken = 1'b1;
    else if (k == 4'd10) taken = zf;
    else if (k == 4'd11) taken = !zf;
    else if (k == 4'd12) taken = cf;
    else if (k == 4'd13) skip = zf;
    inc = !taken;
    return {skip, inc, inm, wr, alu, pce, 1'b0};
  endfunction

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // One clock: drive inputs just after an edge, compare at the falling edge,
  // then advance the model across the next rising edge.
  task automatic cycle(input logic [5:0] opc, input logic z, input logic c);
    int st;
    bus.Opcode = opc; bus.zero = z; bus.carry = c;
    @(negedge clk);
    st = m_state();
    last_out = dut_out();
    chk("cycle", last_out, m_expect(st, opc, m_zf, m_cf));
    @(posedge clk);
    if (st == ST_EXEC) begin
      if (!opc[5]) begin m_zf = z; m_cf = c; end
      if (opc[5:2] == 4'hF) m_halt = 1'b1;
    end
    m_k++;
    #1;
  endtask

  task automatic align_fetch();
    for (int i = 0; i < 4 && m_state() != ST_FETCH; i++) cycle(6'b111000, 1'b0, 1'b0);
    if (m_state() != ST_FETCH) chk("align", 9'd0, 9'd1);
  endtask

  typedef struct {
    string      name;
    logic [5:0] op;
    logic       fz;
    logic       fc;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{"alu101",   6'b010100, 1'b0, 1'b0, 9'b0_1_0_1_101_1_0};
    vecs[1]  = '{"jz_z1",    6'b101000, 1'b1, 1'b0, 9'b0_0_0_0_000_1_0};
    vecs[2]  = '{"jz_z0",    6'b101001, 1'b0, 1'b1, 9'b0_1_0_0_000_1_0};
    vecs[3]  = '{"jnz_z0",   6'b101100, 1'b0, 1'b0, 9'b0_0_0_0_000_1_0};
    vecs[4]  = '{"jnz_z1",   6'b101110, 1'b1, 1'b1, 9'b0_1_0_0_000_1_0};
    vecs[5]  = '{"skz_z1",   6'b110100, 1'b1, 1'b0, 9'b1_1_0_0_000_1_0};
    vecs[6]  = '{"skz_z0",   6'b110111, 1'b0, 1'b1, 9'b0_1_0_0_000_1_0};
    vecs[7]  = '{"jc_c1",    6'b110000, 1'b0, 1'b1, 9'b0_0_0_0_000_1_0};
    vecs[8]  = '{"jc_c0",    6'b110010, 1'b1, 1'b0, 9'b0_1_0_0_000_1_0};
    vecs[9]  = '{"j",        6'b100100, 1'b0, 1'b0, 9'b0_0_0_0_000_1_0};
    vecs[10] = '{"li",       6'b100000, 1'b1, 1'b1, 9'b0_1_1_1_000_1_0};
    vecs[11] = '{"nop",      6'b111000, 1'b1, 1'b0, 9'b0_1_0_0_000_1_0};
    vecs[12] = '{"alu000",   6'b000011, 1'b0, 1'b1, 9'b0_1_0_1_000_1_0};

    bus.Opcode = 6'd0; bus.zero = 1'b0; bus.carry = 1'b0;

    // Reset state and release
    #3;
    chk("reset_idle", dut_out(), IDLE);
    @(posedge clk); #1;
    reset = 1'b1; m_k = 0;
    cycle(6'b000100, 1'b1, 1'b1);
    chk("init_idle", last_out, IDLE);
    cycle(6'b000100, 1'b1, 1'b1);
    chk("fetch_idle", last_out, IDLE);
    cycle(6'b010100, 1'b1, 1'b0);
    chk("first_exec", last_out, 9'b0_1_0_1_101_1_0);

    // Decode table: set flags with an ALU op, then execute the vector opcode
    // with the live zero/carry inverted so only the registered flags can match.
    foreach (vecs[i]) begin
      align_fetch();
      cycle(6'b111000, 1'b0, 1'b0);
      cycle(6'b000000, vecs[i].fz, vecs[i].fc);
      cycle(6'b111000, 1'b0, 1'b0);
      cycle(vecs[i].op, !vecs[i].fz, !vecs[i].fc);
      chk(vecs[i].name, last_out, vecs[i].exp);
    end

    // Flags hold across LI: ALU sets Z, LI with zero=0, JZ still jumps.
    align_fetch();
    cycle(6'b111000, 1'b0, 1'b0);
    cycle(6'b001000, 1'b1, 1'b0);
    cycle(6'b111000, 1'b0, 1'b0);
    cycle(6'b100000, 1'b0, 1'b0);
    cycle(6'b111000, 1'b0, 1'b0);
    cycle(6'b101000, 1'b0, 1'b0);
    chk("li_keeps_zf", last_out, 9'b0_0_0_0_000_1_0);

    // Randomized opcodes (HALT excluded) against the model
    for (int i = 0; i < 300; i++) begin
      logic [5:0] r;
      r = 6'($urandom);
      if (r[5:2] == 4'hF) r[5:2] = 4'hE;
      cycle(r, 1'($urandom), 1'($urandom));
    end

    // Reset in EXEC of an ALU op cancels it and clears the flags.
    align_fetch();
    cycle(6'b111000, 1'b0, 1'b0);
    cycle(6'b001000, 1'b1, 1'b1);
    cycle(6'b111000, 1'b0, 1'b0);
    bus.Opcode = 6'b000100; bus.zero = 1'b1; bus.carry = 1'b1;
    #2;
    chk("we_before_rst", {8'd0, bus.we}, 9'd1);
    reset = 1'b0;
    #1;
    chk("we_pc_en_async", {7'd0, bus.we, bus.pc_en}, 9'd0);
    chk("flags_cleared", {7'd0, dut.zf, dut.cf}, 9'd0);
    m_k = 0; m_zf = 1'b0; m_cf = 1'b0; m_halt = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    cycle(6'b111000, 1'b0, 1'b0);
    cycle(6'b111000, 1'b0, 1'b0);
    cycle(6'b101000, 1'b1, 1'b1);
    chk("jz_after_rst", last_out, 9'b0_1_0_0_000_1_0);
    cycle(6'b111000, 1'b0, 1'b0);
    cycle(6'b110000, 1'b1, 1'b1);
    chk("jc_after_rst", last_out, 9'b0_1_0_0_000_1_0);

    // HALT: no PC update in EXEC, then absorbing
    align_fetch();
    cycle(6'b111000, 1'b0, 1'b0);
    cycle(6'b111111, 1'b0, 1'b0);
    chk("halt_exec", last_out, 9'b0_1_0_0_000_0_0);
    for (int i = 0; i < 6; i++) begin
      cycle(6'($urandom), 1'($urandom), 1'($urandom));
      chk("halted", last_out, 9'b0_1_0_0_000_0_1);
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
